// File: rtl/processor_status_full_pkg.sv
// rtl/processor_status_full_pkg.sv - shared 6502 status flag constants
package cpu6502_pkg;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_I = 2;
   localparam int FLAG_D = 3;
   localparam int FLAG_B = 4;
   localparam int FLAG_U = 5;
   localparam int FLAG_V = 6;
   localparam int FLAG_N = 7;

   localparam logic [7:0] P_RESET = 8'h24;

endpackage

// File: rtl/processor_status_full_if.sv
// rtl/processor_status_full_if.sv - decoder/ALU to status-register signal bundle
interface processor_status_full_if;

   logic [7:0] i_db;
   logic       i_ir5;
   logic       i_acr;
   logic       i_avr;
   logic       i_so_n;
   logic       i_sync;
   logic       i_b_push;
   logic       i_db0_c;
   logic       i_ir5_c;
   logic       i_acr_c;
   logic       i_db1_z;
   logic       i_dbz_z;
   logic       i_db2_i;
   logic       i_ir5_i;
   logic       i_1_i;
   logic       i_db3_d;
   logic       i_ir5_d;
   logic       i_db6_v;
   logic       i_avr_v;
   logic       i_0_v;
   logic       i_db7_n;
   logic [7:0] o_p;
   logic       o_decimal;
   logic       o_irq_mask;

   modport master (
      output i_db, i_ir5, i_acr, i_avr, i_so_n, i_sync, i_b_push,
      output i_db0_c, i_ir5_c, i_acr_c, i_db1_z, i_dbz_z,
      output i_db2_i, i_ir5_i, i_1_i, i_db3_d, i_ir5_d,
      output i_db6_v, i_avr_v, i_0_v, i_db7_n,
      input  o_p, o_decimal, o_irq_mask
   );

   modport slave (
      input  i_db, i_ir5, i_acr, i_avr, i_so_n, i_sync, i_b_push,
      input  i_db0_c, i_ir5_c, i_acr_c, i_db1_z, i_dbz_z,
      input  i_db2_i, i_ir5_i, i_1_i, i_db3_d, i_ir5_d,
      input  i_db6_v, i_avr_v, i_0_v, i_db7_n,
      output o_p, o_decimal, o_irq_mask
   );

endinterface

// File: rtl/processor_status_full_so_edge_detect.sv
// rtl/processor_status_full_so_edge_detect.sv - Set-Overflow pin falling-edge detector
// The event is combinational from the registered previous pin level, so it acts on the same edge.
module so_edge_detect (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_so_n,
   output logic o_event
);

   logic so_q;
   logic so_d;

   assign so_d    = i_so_n;
   assign o_event = so_q & ~i_so_n;

   always_ff @(negedge i_clk) begin
      if (i_reset) begin
         so_q <= 1'b1;
      end else begin
         so_q <= so_d;
      end
   end

endmodule

// File: rtl/processor_status_full.sv
// rtl/processor_status_full.sv - 6502/2A03 processor status register with SO input and IRQ mask lag
// All state changes on the falling edge of i_clk; each flag has its own priority-ordered next-state logic.
module processor_status_full
   import cpu6502_pkg::*;
#(
   parameter bit RESET_I    = 1'b1,
   parameter bit DECIMAL_EN = 1'b0
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   processor_status_full_if.slave   bus
);

   logic c_q, c_d;
   logic z_q, z_d;
   logic i_q, i_d;
   logic d_q, d_d;
   logic v_q, v_d;
   logic n_q, n_d;
   logic irq_mask_q, irq_mask_d;
   logic so_event;

   so_edge_detect u_so_edge_detect (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_so_n  (bus.i_so_n),
      .o_event (so_event)
   );

   always_comb begin
      c_d = c_q;
      if (bus.i_acr_c) begin
         c_d = bus.i_acr;
      end else if (bus.i_db0_c) begin
         c_d = bus.i_db[0];
      end else if (bus.i_ir5_c) begin
         c_d = bus.i_ir5;
      end
   end

   always_comb begin
      z_d = z_q;
      if (bus.i_dbz_z) begin
         z_d = ~|bus.i_db;
      end else if (bus.i_db1_z) begin
         z_d = bus.i_db[1];
      end
   end

   always_comb begin
      i_d = i_q;
      if (bus.i_1_i) begin
         i_d = 1'b1;
      end else if (bus.i_db2_i) begin
         i_d = bus.i_db[2];
      end else if (bus.i_ir5_i) begin
         i_d = bus.i_ir5;
      end
   end

   always_comb begin
      d_d = d_q;
      if (bus.i_db3_d) begin
         d_d = bus.i_db[3];
      end else if (bus.i_ir5_d) begin
         d_d = bus.i_ir5;
      end
   end

   // An SO event that coincides with any explicit V write is dropped, not deferred.
   always_comb begin
      v_d = v_q;
      if (bus.i_avr_v) begin
         v_d = bus.i_avr;
      end else if (bus.i_db6_v) begin
         v_d = bus.i_db[6];
      end else if (bus.i_0_v) begin
         v_d = 1'b0;
      end else if (so_event) begin
         v_d = 1'b1;
      end
   end

   always_comb begin
      n_d = n_q;
      if (bus.i_db7_n) begin
         n_d = bus.i_db[7];
      end
   end

   // The poller sees I as it stood before the opcode fetch, giving the one-instruction lag.
   always_comb begin
      irq_mask_d = irq_mask_q;
      if (bus.i_1_i) begin
         irq_mask_d = 1'b1;
      end else if (bus.i_sync) begin
         irq_mask_d = i_q;
      end
   end

   always_ff @(negedge i_clk) begin
      if (i_reset) begin
         c_q        <= P_RESET[FLAG_C];
         z_q        <= P_RESET[FLAG_Z];
         i_q        <= RESET_I;
         d_q        <= P_RESET[FLAG_D];
         v_q        <= P_RESET[FLAG_V];
         n_q        <= P_RESET[FLAG_N];
         irq_mask_q <= RESET_I;
      end else begin
         c_q        <= c_d;
         z_q        <= z_d;
         i_q        <= i_d;
         d_q        <= d_d;
         v_q        <= v_d;
         n_q        <= n_d;
         irq_mask_q <= irq_mask_d;
      end
   end

   always_comb begin
      bus.o_p         = 8'h00;
      bus.o_p[FLAG_C] = c_q;
      bus.o_p[FLAG_Z] = z_q;
      bus.o_p[FLAG_I] = i_q;
      bus.o_p[FLAG_D] = d_q;
      bus.o_p[FLAG_B] = bus.i_b_push;
      bus.o_p[FLAG_U] = 1'b1;
      bus.o_p[FLAG_V] = v_q;
      bus.o_p[FLAG_N] = n_q;
   end

   assign bus.o_decimal  = d_q & DECIMAL_EN;
   assign bus.o_irq_mask = irq_mask_q;

endmodule

// File: tb/tb_processor_status_full.sv
// tb/tb_processor_status_full.sv - scoreboard bench for processor_status_full (2A03 and NMOS builds)
module tb_processor_status_full;

   typedef struct packed {
      logic       reset;
      logic [7:0] db;
      logic       ir5, acr, avr, so_n, sync, b_push;
      logic       db0_c, ir5_c, acr_c, db1_z, dbz_z;
      logic       db2_i, ir5_i, one_i, db3_d, ir5_d;
      logic       db6_v, avr_v, zero_v, db7_n;
   } stim_t;

   typedef struct packed {
      logic [7:0] p;
      logic       mask;
      logic       d_flag;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   processor_status_full_if if_a ();
   processor_status_full_if if_b ();

   processor_status_full #(.RESET_I(1'b1), .DECIMAL_EN(1'b0)) dut_2a03 (
      .i_clk(clk), .i_reset(rst), .bus(if_a.slave)
   );
   processor_status_full #(.RESET_I(1'b1), .DECIMAL_EN(1'b1)) dut_nmos (
      .i_clk(clk), .i_reset(rst), .bus(if_b.slave)
   );

   assign if_b.i_db     = if_a.i_db;
   assign if_b.i_ir5    = if_a.i_ir5;
   assign if_b.i_acr    = if_a.i_acr;
   assign if_b.i_avr    = if_a.i_avr;
   assign if_b.i_so_n   = if_a.i_so_n;
   assign if_b.i_sync   = if_a.i_sync;
   assign if_b.i_b_push = if_a.i_b_push;
   assign if_b.i_db0_c  = if_a.i_db0_c;
   assign if_b.i_ir5_c  = if_a.i_ir5_c;
   assign if_b.i_acr_c  = if_a.i_acr_c;
   assign if_b.i_db1_z  = if_a.i_db1_z;
   assign if_b.i_dbz_z  = if_a.i_dbz_z;
   assign if_b.i_db2_i  = if_a.i_db2_i;
   assign if_b.i_ir5_i  = if_a.i_ir5_i;
   assign if_b.i_1_i    = if_a.i_1_i;
   assign if_b.i_db3_d  = if_a.i_db3_d;
   assign if_b.i_ir5_d  = if_a.i_ir5_d;
   assign if_b.i_db6_v  = if_a.i_db6_v;
   assign if_b.i_avr_v  = if_a.i_avr_v;
   assign if_b.i_0_v    = if_a.i_0_v;
   assign if_b.i_db7_n  = if_a.i_db7_n;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Reference model: architectural flags as a byte, previous SO pin level, poller mask.
   logic [7:0] m_flags;
   logic       m_so_prev;
   logic       m_mask;

   task automatic model_step(input stim_t s, output exp_t e);
      logic ev;
      logic old_i;
      if (s.reset) begin
         m_flags   = 8'h04;
         m_mask    = 1'b1;
         m_so_prev = 1'b1;
      end else begin
         ev        = m_so_prev && !s.so_n;
         m_so_prev = s.so_n;
         old_i     = m_flags[2];
         if (s.acr_c)      m_flags[0] = s.acr;
         else if (s.db0_c) m_flags[0] = s.db[0];
         else if (s.ir5_c) m_flags[0] = s.ir5;
         if (s.dbz_z)      m_flags[1] = (s.db == 8'd0);
         else if (s.db1_z) m_flags[1] = s.db[1];
         if (s.one_i)      m_flags[2] = 1'b1;
         else if (s.db2_i) m_flags[2] = s.db[2];
         else if (s.ir5_i) m_flags[2] = s.ir5;
         if (s.db3_d)      m_flags[3] = s.db[3];
         else if (s.ir5_d) m_flags[3] = s.ir5;
         if (s.avr_v)       m_flags[6] = s.avr;
         else if (s.db6_v)  m_flags[6] = s.db[6];
         else if (s.zero_v) m_flags[6] = 1'b0;
         else if (ev)       m_flags[6] = 1'b1;
         if (s.db7_n)      m_flags[7] = s.db[7];
         if (s.one_i)      m_mask = 1'b1;
         else if (s.sync)  m_mask = old_i;
      end
      e.p      = {m_flags[7:6], 1'b1, s.b_push, m_flags[3:0]};
      e.mask   = m_mask;
      e.d_flag = m_flags[3];
   endtask

   function automatic stim_t idle();
      stim_t s;
      s      = '0;
      s.so_n = 1'b1;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      exp_t e;
      @(posedge clk);
      #1;
      rst           = s.reset;
      if_a.i_db     = s.db;
      if_a.i_ir5    = s.ir5;
      if_a.i_acr    = s.acr;
      if_a.i_avr    = s.avr;
      if_a.i_so_n   = s.so_n;
      if_a.i_sync   = s.sync;
      if_a.i_b_push = s.b_push;
      if_a.i_db0_c  = s.db0_c;
      if_a.i_ir5_c  = s.ir5_c;
      if_a.i_acr_c  = s.acr_c;
      if_a.i_db1_z  = s.db1_z;
      if_a.i_dbz_z  = s.dbz_z;
      if_a.i_db2_i  = s.db2_i;
      if_a.i_ir5_i  = s.ir5_i;
      if_a.i_1_i    = s.one_i;
      if_a.i_db3_d  = s.db3_d;
      if_a.i_ir5_d  = s.ir5_d;
      if_a.i_db6_v  = s.db6_v;
      if_a.i_avr_v  = s.avr_v;
      if_a.i_0_v    = s.zero_v;
      if_a.i_db7_n  = s.db7_n;
      model_step(s, e);
      exp_q.push_back(e);
   endtask

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s vec %0d: got %02h expected %02h", name, n_vec, act, req);
      end
   endtask

   // Monitor: outputs for a vector issued before falling edge k are sampled at the next rising edge.
   always @(posedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         cmp("o_p_2a03",       if_a.o_p,                 e.p);
         cmp("o_p_nmos",       if_b.o_p,                 e.p);
         cmp("irq_mask_2a03",  {7'd0, if_a.o_irq_mask},  {7'd0, e.mask});
         cmp("irq_mask_nmos",  {7'd0, if_b.o_irq_mask},  {7'd0, e.mask});
         cmp("decimal_2a03",   {7'd0, if_a.o_decimal},   8'd0);
         cmp("decimal_nmos",   {7'd0, if_b.o_decimal},   {7'd0, e.d_flag});
      end
   end

   initial begin
      stim_t s;
      logic  so_lvl;

      s = idle(); s.reset = 1'b1;
      apply(s); apply(s);

      // PLP/RTI style load of every flag from DB.
      s = idle();
      s.db0_c = 1'b1; s.db1_z = 1'b1; s.db2_i = 1'b1;
      s.db3_d = 1'b1; s.db6_v = 1'b1; s.db7_n = 1'b1;
      s.db = 8'hFF; apply(s);
      s.db = 8'h00; apply(s);
      s.db = 8'h00; s.dbz_z = 1'b1; apply(s);

      s = idle(); s.acr_c = 1'b1; s.acr = 1'b1; s.db0_c = 1'b1; s.db = 8'h00;
      apply(s);

      // Explicit V write swallows a coincident SO event; the held-low pin must not re-fire.
      s = idle(); apply(s);
      s = idle(); s.avr_v = 1'b1; s.avr = 1'b0; s.so_n = 1'b0; apply(s);
      s = idle(); s.so_n = 1'b0; apply(s);
      s = idle(); apply(s);

      for (int k = 0; k < 5; k++) begin
         s = idle(); s.so_n = 1'b0; apply(s);
      end
      s = idle(); s.so_n = 1'b0; s.zero_v = 1'b1; apply(s);
      s = idle(); s.so_n = 1'b0; apply(s); apply(s);
      s = idle(); apply(s);

      // IRQ mask lag across SEI, CLI and the interrupt sequence.
      s = idle(); s.ir5_i = 1'b1; s.ir5 = 1'b1; apply(s);
      s = idle(); s.sync = 1'b1; apply(s);
      s = idle(); s.ir5_i = 1'b1; s.ir5 = 1'b0; apply(s);
      s = idle(); apply(s); apply(s);
      s = idle(); s.sync = 1'b1; apply(s);
      s = idle(); s.one_i = 1'b1; s.sync = 1'b1; apply(s);
      s = idle(); apply(s);

      s = idle(); s.ir5_d = 1'b1; s.ir5 = 1'b1; apply(s);
      s = idle(); s.b_push = 1'b1; apply(s);
      s = idle(); s.ir5_d = 1'b1; s.ir5 = 1'b0; apply(s);

      so_lvl = 1'b1;
      for (int k = 0; k < 600; k++) begin
         s        = '0;
         s.reset  = ($urandom_range(0, 59) == 0);
         s.db     = 8'($urandom);
         s.ir5    = 1'($urandom);
         s.acr    = 1'($urandom);
         s.avr    = 1'($urandom);
         s.b_push = 1'($urandom);
         s.sync   = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) so_lvl = ~so_lvl;
         s.so_n   = so_lvl;
         s.db0_c  = ($urandom_range(0, 5) == 0);
         s.ir5_c  = ($urandom_range(0, 5) == 0);
         s.acr_c  = ($urandom_range(0, 5) == 0);
         s.db1_z  = ($urandom_range(0, 5) == 0);
         s.dbz_z  = ($urandom_range(0, 5) == 0);
         s.db2_i  = ($urandom_range(0, 5) == 0);
         s.ir5_i  = ($urandom_range(0, 5) == 0);
         s.one_i  = ($urandom_range(0, 9) == 0);
         s.db3_d  = ($urandom_range(0, 5) == 0);
         s.ir5_d  = ($urandom_range(0, 5) == 0);
         s.db6_v  = ($urandom_range(0, 7) == 0);
         s.avr_v  = ($urandom_range(0, 7) == 0);
         s.zero_v = ($urandom_range(0, 7) == 0);
         s.db7_n  = ($urandom_range(0, 5) == 0);
         apply(s);
      end

      for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
         @(negedge clk);
      end
      if (exp_q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: got %0d outstanding vectors expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
